jtdd_snd_out: RTL and testbench

- Output conditioning stage directly downstream of the Double Dragon game top; consumes its mono `snd`/`sample` pair.
- Removes DC offset with a one-pole high-pass and applies the `dip_fxlevel` gain with saturation.
- Re-times the result onto a fixed-rate output strobe (zero-order hold) for the platform audio path.
- Runs entirely in the 48 MHz `clk` domain.

---
 rtl/jtdd_snd_out.sv | 100 ++++++++++
 tb/tb_jtdd_snd_out.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_snd_out.sv
// Output conditioning for the Double Dragon mono sound stream:
// DC-blocking high-pass, selectable gain with saturation, and a
// fixed-rate zero-order-hold output strobe. Single clock domain (clk).
module jtdd_snd_out #(
    parameter int unsigned DIV = 1000,  // clk cycles per output sample
    parameter int unsigned SH  = 10     // DC-blocker time-constant shift
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] snd,
    input  logic               sample,
    input  logic        [1:0]  dip_fxlevel,
    input  logic               enable,
    output logic signed [15:0] snd_out,
    output logic               snd_stb
);

    localparam int unsigned AW   = 16 + SH;
    localparam logic [15:0] LAST = 16'(DIV - 1);

    // Pipeline state
    logic signed [15:0]   x;
    logic                 v1;
    logic signed [AW-1:0] acc;
    logic signed [15:0]   hp;
    logic                 v2;
    logic signed [15:0]   held;

    // Output pacer
    logic [15:0] cnt;

    // Combinational datapath
    logic signed [16:0] avg;
    logic signed [16:0] y;
    logic signed [17:0] hp18;
    logic signed [17:0] g;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7fff;
        else if (v < 18'sh38000)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // High-pass difference against the running mean, and gain selection
    always_comb begin
        avg  = 17'(acc >>> SH);
        y    = {x[15], x} - avg;
        hp18 = 18'(hp);
        case (dip_fxlevel)
            2'd0:    g = hp18 >>> 1;
            2'd1:    g = hp18;
            2'd2:    g = hp18 + (hp18 >>> 1);
            2'd3:    g = hp18 <<< 1;
            default: g = hp18;
        endcase
    end

    // Three-stage sample pipeline: capture, DC removal, gain/mute
    always_ff @(posedge clk) begin
        if (rst) begin
            x    <= '0;
            v1   <= 1'b0;
            acc  <= '0;
            hp   <= '0;
            v2   <= 1'b0;
            held <= '0;
        end else begin
            v1 <= sample;
            if (sample)
                x <= snd;
            v2 <= v1;
            if (v1) begin
                acc <= acc + AW'(y);
                hp  <= sat16(18'(y));
            end
            if (v2)
                held <= enable ? sat16(g) : '0;
        end
    end

    // Fixed-rate output strobe; snd_out samples held on the wrap cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            snd_stb <= 1'b0;
            snd_out <= '0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            snd_stb <= 1'b1;
            snd_out <= held;
        end else begin
            cnt     <= cnt + 16'd1;
            snd_stb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtdd_snd_out.sv
// Self-checking bench for jtdd_snd_out: directed scenarios plus a
// randomized phase, all compared against a behavioural model.
module tb_jtdd_snd_out;

    localparam int DIV = 8;
    localparam int SH  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] snd = '0;
    logic               sample = 1'b0;
    logic        [1:0]  dip_fxlevel = 2'd1;
    logic               enable = 1'b1;
    logic signed [15:0] snd_out;
    logic               snd_stb;

    int n_checks = 0;
    int n_err    = 0;

    jtdd_snd_out #(.DIV(DIV), .SH(SH)) dut (
        .clk         (clk),
        .rst         (rst),
        .snd         (snd),
        .sample      (sample),
        .dip_fxlevel (dip_fxlevel),
        .enable      (enable),
        .snd_out     (snd_out),
        .snd_stb     (snd_stb)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        longint hp;
        longint due;
    } ent_t;

    ent_t               q[$];
    longint             m_acc   = 0;
    longint             edge_no = 0;
    int                 m_cnt   = 0;
    logic signed [15:0] m_held  = '0;
    logic signed [15:0] m_out   = '0;
    logic               m_stb   = 1'b0;

    // floor(a / 2^sh) by plain division
    function automatic longint fdiv2(longint a, int sh);
        longint d;
        longint r;
        d = longint'(1) << sh;
        r = a / d;
        if (a < 0 && r * d != a) r = r - 1;
        return r;
    endfunction

    function automatic longint clamp16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint gain(longint h, int lvl);
        case (lvl)
            0:       return fdiv2(h, 1);
            1:       return h;
            2:       return h + fdiv2(h, 1);
            default: return 2 * h;
        endcase
    endfunction

    always @(posedge clk) begin
        longint y;
        if (rst) begin
            m_acc  = 0;
            m_cnt  = 0;
            m_held = '0;
            m_out  = '0;
            m_stb  = 1'b0;
            q.delete();
        end else begin
            m_cnt++;
            if (m_cnt % DIV == 0) begin
                m_stb = 1'b1;
                m_out = m_held;
            end else begin
                m_stb = 1'b0;
            end
            if (q.size() > 0 && q[0].due == edge_no) begin
                m_held = enable ? 16'(clamp16(gain(q[0].hp, int'(dip_fxlevel)))) : 16'sd0;
                void'(q.pop_front());
            end
            if (sample) begin
                y = longint'(snd) - fdiv2(m_acc, SH);
                m_acc = m_acc + y;
                q.push_back('{clamp16(y), edge_no + 2});
            end
        end
        edge_no++;
    end

    // ---------------- checking helpers ----------------
    logic               track = 1'b0;
    logic signed [15:0] prev_out = '0;
    int                 mono_bad = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("stb", 64'(snd_stb), 64'(m_stb));
        chk("out", 64'(snd_out), 64'(m_out));
        if (track && snd_stb === 1'b1) begin
            if (snd_out > prev_out) mono_bad++;
            prev_out = snd_out;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sample = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] v);
        snd    = v;
        sample = 1'b1;
        step();
        sample = 1'b0;
    endtask

    task automatic wait_stb();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (snd_stb !== 1'b1 && n < 3 * DIV);
        if (snd_stb !== 1'b1) chk("stb_timeout", 64'(snd_stb), 64'sd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state, idle strobe cadence
        step();
        do_reset();
        chk("reset_out", 64'(snd_out), 64'sd0);
        chk("reset_stb", 64'(snd_stb), 64'sd0);
        for (int i = 1; i <= 3 * DIV; i++) begin
            step();
            chk("idle_stb", 64'(snd_stb), (i % DIV == 0) ? 64'sd1 : 64'sd0);
            chk("idle_out", 64'(snd_out), 64'sd0);
        end

        // Single sample passes through unity gain, then DC tracking kicks in
        do_reset();
        dip_fxlevel = 2'd1;
        enable      = 1'b1;
        send(16'sd1000);
        wait_stb();
        chk("first_1000", 64'(snd_out), 64'sd1000);
        send(16'sd1000);
        wait_stb();
        chk("second_938", 64'(snd_out), 64'sd938);

        // Constant input decays toward zero, monotonically
        do_reset();
        track    = 1'b1;
        prev_out = 16'sh7fff;
        mono_bad = 0;
        for (int i = 0; i < 400; i++) begin
            send(16'sd1000);
            step();
            step();
            step();
        end
        wait_stb();
        track = 1'b0;
        chk("decay_mono", 64'(mono_bad), 64'sd0);
        chk("decay_small", 64'((snd_out <= 16'sd16) && (snd_out >= -16'sd16)), 64'sd1);

        // Saturation and rounding of the gain stage
        do_reset();
        dip_fxlevel = 2'd3;
        send(16'sd20000);
        wait_stb();
        chk("sat_pos", 64'(snd_out), 64'sd32767);
        do_reset();
        send(-16'sd20000);
        wait_stb();
        chk("sat_neg", 64'(snd_out), -64'sd32768);
        do_reset();
        dip_fxlevel = 2'd0;
        send(-16'sd3);
        wait_stb();
        chk("half_neg3", 64'(snd_out), -64'sd2);

        // Mute keeps DC tracking alive
        do_reset();
        dip_fxlevel = 2'd1;
        enable      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(16'sd5000);
            step();
            step();
            step();
        end
        wait_stb();
        chk("mute_zero", 64'(snd_out), 64'sd0);
        enable = 1'b1;
        send(16'sd5000);
        step();
        step();
        step();
        wait_stb();
        chk("unmute_range", 64'((snd_out > 16'sd0) && (snd_out < 16'sd5000)), 64'sd1);

        // Reset while a sample is in flight
        do_reset();
        send(16'sd1000);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 3 * DIV; i++) begin
            step();
            chk("rst_flight_out", 64'(snd_out), 64'sd0);
            chk("rst_flight_stb", 64'(snd_stb), (i % DIV == 0) ? 64'sd1 : 64'sd0);
        end

        // Randomized traffic, including back-to-back samples and rare resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sample = ($urandom_range(0, 2) == 0);
            snd    = 16'($urandom);
            if ($urandom_range(0, 31) == 0) dip_fxlevel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst    = 1'b0;
        sample = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
